// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider (divider_seq).
package div_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        FIX  = 3'd2,
        ZERO = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int DIV_W_DEFAULT = 3;

    // Counter must hold the value W itself, hence W+1 codes.
    function automatic int div_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {acum,q} left, subtract divisor when it fits.
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic [W:0]   acum,
    input  logic [W-1:0] q,
    input  logic [W-1:0] A,
    output logic [W:0]   acum_next,
    output logic [W-1:0] q_next
);

    logic [W:0] shifted;
    logic       ge;

    assign shifted   = {acum[W-1:0], q[W-1]};
    // acum stays below the divisor, so its top bit only matters as an overflow guard.
    assign ge        = acum[W] | (shifted >= {1'b0, A});
    assign acum_next = ge ? (shifted - {1'b0, A}) : shifted;
    assign q_next    = {q[W-2:0], ge};

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock, init/busy/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (adds the FIX sign-correction state).
module divider_seq
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] R,
    output logic [W-1:0] rem,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int CNT_W = div_cnt_w(W);

    state_t           state, state_nxt;
    logic [W:0]       acum, acum_nxt;
    logic [W-1:0]     q, q_nxt;
    logic [W-1:0]     dvsr;
    logic [W-1:0]     b_lat;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     a_core, b_core;

`ifdef DIVIDER_SIGNED_EN
    logic neg_q, neg_r;

    // The core always works on magnitudes; signs are reapplied in FIX.
    assign a_core = A[W-1] ? -A : A;
    assign b_core = B[W-1] ? -B : B;
`else
    assign a_core = A;
    assign b_core = B;
`endif

    div_step #(.W(W)) u_step (
        .acum      (acum),
        .q         (q),
        .A         (dvsr),
        .acum_next (acum_nxt),
        .q_next    (q_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (init) state_nxt = (A == '0) ? ZERO : RUN;
            RUN: begin
                if (cnt == CNT_W'(1)) begin
`ifdef DIVIDER_SIGNED_EN
                    state_nxt = FIX;
`else
                    state_nxt = DONE;
`endif
                end
            end
            FIX:     state_nxt = DONE;
            ZERO:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FIX) || (state == ZERO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acum     <= '0;
            q        <= '0;
            cnt      <= '0;
            dvsr     <= '0;
            b_lat    <= '0;
            R        <= '0;
            rem      <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (init) begin
                        dvsr     <= a_core;
                        b_lat    <= B;
                        acum     <= '0;
                        q        <= b_core;
                        cnt      <= CNT_W'(W);
                        div_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
                        neg_q    <= A[W-1] ^ B[W-1];
                        neg_r    <= B[W-1];
`endif
                    end
                end
                RUN: begin
                    acum <= acum_nxt;
                    q    <= q_nxt;
                    cnt  <= cnt - CNT_W'(1);
                end
`ifdef DIVIDER_SIGNED_EN
                FIX: begin
                    if (neg_q) q    <= -q;
                    if (neg_r) acum <= -acum;
                end
`endif
                ZERO: begin
                    R        <= '1;
                    rem      <= b_lat;
                    div_zero <= 1'b1;
                end
                DONE: begin
                    // A divide-by-zero result was already loaded in ZERO.
                    if (!div_zero) begin
                        R   <= q;
                        rem <= acum[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Randomised self-checking bench for divider_seq against an arithmetic reference model.
module tb_divider_seq;

    localparam int W = 8;
`ifdef DIVIDER_SIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         init;
    logic [W-1:0] A, B, R, rem;
    logic         busy, done, div_zero;

    int vectors     = 0;
    int miscompares = 0;

    divider_seq #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .A        (A),
        .B        (B),
        .R        (R),
        .rem      (rem),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a = divisor, b = dividend.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [W-1:0] rm,
                                  output logic dz, output int lat);
        int sa, sb;
        if (a == '0) begin
            r = '1; rm = b; dz = 1'b1; lat = 2;
        end else begin
            dz  = 1'b0;
            lat = LAT;
`ifdef DIVIDER_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            if (sb == -(1 << (W - 1)) && sa == -1) begin
                r = b; rm = '0;
            end else begin
                r  = W'(sb / sa);
                rm = W'(sb % sa);
            end
`else
            sa = 0; sb = 0;
            r  = b / a;
            rm = b % a;
`endif
        end
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er, erem;
        logic         edz;
        int           elat, seen, busy_n;
        model(a, b, er, erem, edz, elat);
        A = a; B = b; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        busy_n = busy ? 1 : 0;
        seen = 0;
        for (int j = 1; j <= 4 * W; j++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = j;
                break;
            end
            if (busy) busy_n++;
        end
        check_eq("latency", 32'(seen), 32'(elat));
        check_eq("busy_cycles", 32'(busy_n), 32'(elat - 1));
        check_eq("busy_at_done", 32'(busy), 32'(0));
        check_eq("R", 32'(R), 32'(er));
        check_eq("rem", 32'(rem), 32'(erem));
        check_eq("div_zero", 32'(div_zero), 32'(edz));
        @(posedge clk); #1;
        check_eq("done_pulse", 32'(done), 32'(0));
        check_eq("R_hold", 32'(R), 32'(er));
    endtask

    initial begin
        logic [W-1:0] er, erem;
        logic         edz;
        int           elat, pulses, last, dcount;
        logic [W-1:0] ra;

        reset = 1'b1; init = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_R", 32'(R), 32'(0));
        check_eq("rst_rem", 32'(rem), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_done", 32'(done), 32'(0));
        check_eq("rst_dz", 32'(div_zero), 32'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(8'd2, 8'd7);
        run_op(8'd7, 8'd200);
        run_op(8'd0, 8'd5);
        run_op(8'd3, 8'd6);
        run_op(8'd2, 8'hF9);
        run_op(8'hFF, 8'h80);
        run_op(8'd0, 8'hF9);
        run_op(8'd1, 8'hFF);
        run_op(8'hFF, 8'hFE);
        run_op(8'h80, 8'h7F);

        // init held high: operations chain with one IDLE cycle between them
        model(8'd10, 8'd100, er, erem, edz, elat);
        A = 8'd10; B = 8'd100; init = 1'b1;
        pulses = 0; last = 0;
        for (int c = 1; c <= 6 * (LAT + 1) && pulses < 3; c++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                check_eq("b2b_R", 32'(R), 32'(er));
                check_eq("b2b_rem", 32'(rem), 32'(erem));
                if (pulses == 1) check_eq("b2b_first", 32'(c), 32'(LAT + 1));
                else             check_eq("b2b_gap", 32'(c - last), 32'(LAT + 1));
                last = c;
            end
        end
        init = 1'b0;
        check_eq("b2b_pulses", 32'(pulses), 32'(3));
        @(posedge clk); #1;

        // asynchronous reset in the middle of RUN
        A = 8'd7; B = 8'd200; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy), 32'(0));
        check_eq("arst_done", 32'(done), 32'(0));
        check_eq("arst_R", 32'(R), 32'(0));
        check_eq("arst_rem", 32'(rem), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        dcount = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check_eq("arst_no_done", 32'(dcount), 32'(0));
        run_op(8'd7, 8'd200);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            if ($urandom_range(0, 7) == 0) ra = '0;
            else if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(1, 4));
            run_op(ra, W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
